// File: rtl/gat_pkg.sv
// Shared types for the GAT layer scheduler: FSM state encoding and the
// field layout of the packed status word.
package gat_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WAIT_LOAD  = 4'd1,
        S_RUN        = 4'd2,
        S_RELOAD_CLR = 4'd3,
        S_RELOAD_SET = 4'd4,
        S_DRAIN      = 4'd5,
        S_DONE       = 4'd6
    } sched_state_t;

    localparam int STATUS_STATE_LSB = 28;
    localparam int STATUS_STATE_W   = 4;
    localparam int STATUS_LAYER_LSB = 24;
    localparam int STATUS_LAYER_W   = 4;
    localparam int STATUS_BEATS_LSB = 0;
    localparam int STATUS_BEATS_W   = 24;

endpackage

// File: rtl/gat_sched_fifo.sv
// Small synchronous FIFO with a registered head word; count includes the
// word currently presented on dout.
module gat_sched_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q;
    logic             do_push, do_pop;

    assign do_pop  = pop & valid_q;
    assign do_push = push & (count_q < CNT_W'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        dout_d   = '0;
        if (count_d != '0) begin
            // The incoming word becomes the head when nothing else remains.
            if (do_push && ((count_q - CNT_W'(do_pop)) == '0)) begin
                dout_d = push_data;
            end else begin
                dout_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/gat_layer_sched.sv
// GAT layer scheduler: gates host load-done flags into the core, steps layers,
// requests weight reloads, then streams the new-feature BRAM out.
module gat_layer_sched
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH          = 32,
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NUM_LAYERS         = 2,
    parameter int BRAM_RD_LATENCY    = 2,
    parameter int FIFO_DEPTH         = 4,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sched_start,
    input  logic                          sched_abort,
    input  logic                          h_data_bram_load_done,
    input  logic                          h_node_info_bram_load_done,
    input  logic                          wgt_bram_load_done,
    output logic                          core_load_done,
    output logic                          gat_layer,
    input  logic                          gat_ready,
    output logic                          wgt_reload_req,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  m_feat_data,
    output logic                          m_feat_valid,
    output logic                          m_feat_last,
    input  logic                          m_feat_ready,
    output logic                          sched_busy,
    output logic                          sched_done,
    output logic [TOP_WIDTH-1:0]          sched_status
);

    localparam int LAYER_W = $clog2(NUM_LAYERS + 1);
    localparam int CNT_W   = $clog2(NEW_FEATURE_DEPTH + 1);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int LAT     = BRAM_RD_LATENCY;

    sched_state_t         state_q, state_d;
    logic [LAYER_W-1:0]   layer_q, layer_d;
    logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]     beats_q, beats_d;
    logic [LAT-1:0]       vld_sr_q, vld_sr_d;
    logic [LAT-1:0]       last_sr_q, last_sr_d;
    logic                 gat_ready_q;
    logic                 core_load_done_q, wgt_reload_req_q, gat_layer_q;
    logic                 sched_busy_q, sched_done_q;
    logic [TOP_WIDTH-1:0] status_q, status_d;

    logic                         gat_rise, all_loaded, issue, handshake, beat_last;
    logic                         fifo_valid;
    logic [NEW_FEATURE_WIDTH:0]   fifo_dout;
    logic [FCNT_W-1:0]            fifo_count;

    assign gat_rise   = gat_ready & ~gat_ready_q;
    assign all_loaded = h_data_bram_load_done & h_node_info_bram_load_done & wgt_bram_load_done;
    assign handshake  = fifo_valid & m_feat_ready;
    assign beat_last  = fifo_dout[NEW_FEATURE_WIDTH];

    // Credit: words already buffered plus reads still in the BRAM pipe.
    assign issue = (state_q == S_DRAIN)
                && (rd_cnt_q < CNT_W'(NEW_FEATURE_DEPTH))
                && ((int'(fifo_count) + $countones(vld_sr_q)) < FIFO_DEPTH);

    always_comb begin
        vld_sr_d  = vld_sr_q;
        last_sr_d = last_sr_q;
        for (int i = LAT - 1; i > 0; i--) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end
        vld_sr_d[0]  = issue;
        last_sr_d[0] = issue && (rd_cnt_q == CNT_W'(NEW_FEATURE_DEPTH - 1));
        if (sched_abort) begin
            vld_sr_d  = '0;
            last_sr_d = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        rd_cnt_d = rd_cnt_q;
        beats_d  = beats_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (sched_start) begin
                    state_d  = S_WAIT_LOAD;
                    layer_d  = '0;
                    rd_cnt_d = '0;
                    beats_d  = '0;
                end
            end
            S_WAIT_LOAD: begin
                if (all_loaded) state_d = S_RUN;
            end
            S_RUN: begin
                if (gat_rise) begin
                    if (layer_q < LAYER_W'(NUM_LAYERS - 1)) begin
                        layer_d = layer_q + LAYER_W'(1);
                        state_d = S_RELOAD_CLR;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_RELOAD_CLR: begin
                if (!wgt_bram_load_done) state_d = S_RELOAD_SET;
            end
            S_RELOAD_SET: begin
                if (wgt_bram_load_done) state_d = S_RUN;
            end
            S_DRAIN: begin
                if (issue) rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (handshake) begin
                    beats_d = beats_q + CNT_W'(1);
                    if (beat_last) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (sched_abort) begin
            state_d  = S_IDLE;
            layer_d  = '0;
            rd_cnt_d = '0;
            beats_d  = '0;
        end
    end

    always_comb begin
        status_d = '0;
        status_d[STATUS_STATE_LSB +: STATUS_STATE_W] = state_d;
        status_d[STATUS_LAYER_LSB +: STATUS_LAYER_W] = STATUS_LAYER_W'(layer_d);
        status_d[STATUS_BEATS_LSB +: STATUS_BEATS_W] = STATUS_BEATS_W'(beats_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            layer_q          <= '0;
            rd_cnt_q         <= '0;
            beats_q          <= '0;
            vld_sr_q         <= '0;
            last_sr_q        <= '0;
            gat_ready_q      <= 1'b0;
            core_load_done_q <= 1'b0;
            wgt_reload_req_q <= 1'b0;
            gat_layer_q      <= 1'b0;
            sched_busy_q     <= 1'b0;
            sched_done_q     <= 1'b0;
            status_q         <= '0;
        end else begin
            state_q          <= state_d;
            layer_q          <= layer_d;
            rd_cnt_q         <= rd_cnt_d;
            beats_q          <= beats_d;
            vld_sr_q         <= vld_sr_d;
            last_sr_q        <= last_sr_d;
            gat_ready_q      <= gat_ready;
            core_load_done_q <= (state_d == S_RUN);
            wgt_reload_req_q <= (state_d == S_RELOAD_CLR) || (state_d == S_RELOAD_SET);
            gat_layer_q      <= layer_d[0];
            sched_busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
            sched_done_q     <= (state_d == S_DONE);
            status_q         <= status_d;
        end
    end

    gat_sched_fifo #(
        .WIDTH (NEW_FEATURE_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (sched_abort),
        .push      (vld_sr_q[LAT-1]),
        .push_data ({last_sr_q[LAT-1], feat_bram_dout}),
        .pop       (m_feat_ready),
        .dout      (fifo_dout),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign feat_bram_addrb = {rd_cnt_q[NEW_FEATURE_ADDR_W-1:0], 2'b00};
    assign core_load_done  = core_load_done_q;
    assign wgt_reload_req  = wgt_reload_req_q;
    assign gat_layer       = gat_layer_q;
    assign sched_busy      = sched_busy_q;
    assign sched_done      = sched_done_q;
    assign sched_status    = status_q;
    assign m_feat_valid    = fifo_valid;
    assign m_feat_data     = fifo_dout[NEW_FEATURE_WIDTH-1:0];
    assign m_feat_last     = beat_last;

endmodule
